grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
// Shares the single GRF write port (we/A3/WD/wpc) between the pipeline writeback stage and the
// multi-cycle mult/div/load-delay unit ("md"). Pipeline writeback has priority and is written
// combinationally the same cycle. md results are queued in a small buffer and drained in idle
// port cycles. An age-based starvation guard is included. Per-register pending flags feed the
// decode stall logic.
// PARAMETERS
// DEPTH     2   md buffer entries (power of 2, >=2)
// MAX_WAIT  4   cycles head may wait before forcing a pipeline stall (>=1)
// PORTS
// clk         in   1   clock, all state on posedge
// reset       in   1   synchronous, active-high
// wb_valid    in   1   pipeline writeback request this cycle
// wb_addr     in   5   pipeline destination register
// wb_data     in   32  pipeline write data
// wb_pc       in   32  pipeline instruction PC (for write log)
// wb_stall    out  1   pipeline must hold wb_* stable next cycle (port taken by md)
// md_valid    in   1   md result offered
// md_ready    out  1   md result accepted when md_valid&&md_ready at posedge
// md_addr     in   5   md destination register
// md_data     in   32  md write data
// md_pc       in   32  md instruction PC
// grf_we      out  1   GRF regWrite
// grf_a3      out  5   GRF A3
// grf_wd      out  32  GRF WD
// grf_wpc     out  32  GRF wpc
// rs_addr     in   5   decode rs query;  rs_pending out 1: buffered write to rs outstanding
// rt_addr     in   5   decode rt query;  rt_pending out 1: buffered write to rt outstanding
// BEHAVIOUR
// - Reset: buffer emptied (count=0, pointers=0), head age=0; while reset=1: grf_we=0, md_ready=0,
//   wb_stall=0, pending=0. Reset mid-operation discards all buffered entries (no GRF write).
// - md_ready = (count<DEPTH) && !reset, from registered count; no push when full even if popping.
//   md with md_addr==0 is accepted (handshake completes) but never enqueued.
// - Grant, evaluated each cycle (combinational):
//   starve = head_valid && age==MAX_WAIT && wb_valid && wb_addr!=0.
//   starve: port<=head, pop head, wb_stall=1, wb not written (re-presented next cycle).
//   else if wb_valid && wb_addr!=0: port<=wb, wb_stall=0.
//   else if head_valid: port<=head, pop head.   else grf_we=0, grf_a3/wd/wpc=0.
//   wb_valid with wb_addr==0: no write, port treated as idle.
// - Latency: md accepted at edge N -> earliest GRF write during cycle N+1 (written at edge N+2).
// - age: 0 when empty or on pop; +1 per cycle head valid and not popped; saturates at MAX_WAIT.
// - Ordering: wb is program-order younger than every buffered entry. When wb is written, every
//   buffered entry with addr==wb_addr is squashed (valid cleared, still occupies slot, popped
//   later with grf_we=0 for that cycle is NOT allowed: squashed head is skipped in the same
//   cycle's pop, taking no port cycle). Squash and push same cycle: new push is not squashed.
// - Simultaneous push and pop: both applied; count unchanged; pointers wrap modulo DEPTH.
// - rs_pending/rt_pending: OR over valid entries of (addr==query) && query!=0; combinational,
//   from registered buffer state (entry visible the cycle after acceptance, clears after pop edge).
// TESTING
// 1 reset=1 for 2 cycles with md_valid=1 -> md_ready=0, grf_we=0; after reset count=0.
// 2 idle wb, md {addr=5,data=0x1234,pc=0x3000} at edge N -> rs_addr=5 pending during N+1,
//   grf_we=1,a3=5,wd=0x1234,wpc=0x3000 during N+1; pending=0 in N+2.
// 3 md push 2 entries, wb_valid=1 addr=8 continuously -> after MAX_WAIT=4 waits wb_stall=1 one
//   cycle, head written, wb written next cycle; md_ready=0 while count==2.
// 4 buffer holds addr=9, wb writes addr=9 data=0xAAAA -> entry squashed, rt_pending(9)=0,
//   GRF never receives stale md value for $9.
// 5 md addr=0 and wb addr=0 -> handshake completes, grf_we=0, no pending flags.
// 6 full buffer, reset pulse mid-stream -> buffered writes dropped, md_ready=1 after reset.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb_arbiter_if
// Brief    : GRF write-port sharing bus: pipeline writeback, md results, decode
//            pending queries and the GRF write port itself.
// Revision : 1.0 - initial release
// ============================================================================
interface grf_wb_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        wb_stall;

  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pc;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_wpc;

  logic [4:0]  rs_addr;
  logic        rs_pending;
  logic [4:0]  rt_addr;
  logic        rt_pending;

  // The arbiter itself
  modport slave (
    input  wb_valid, wb_addr, wb_data, wb_pc,
    output wb_stall,
    input  md_valid, md_addr, md_data, md_pc,
    output md_ready,
    output grf_we, grf_a3, grf_wd, grf_wpc,
    input  rs_addr, rt_addr,
    output rs_pending, rt_pending
  );

  // Surrounding pipeline / md unit / GRF
  modport master (
    output wb_valid, wb_addr, wb_data, wb_pc,
    input  wb_stall,
    output md_valid, md_addr, md_data, md_pc,
    input  md_ready,
    input  grf_we, grf_a3, grf_wd, grf_wpc,
    output rs_addr, rt_addr,
    input  rs_pending, rt_pending
  );
endinterface
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb_arbiter
// Brief    : Shares the GRF write port between pipeline writeback (priority) and
//            a buffered md result queue with an age-based starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  grf_wb_arbiter_if.slave   bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_AGE_W = $clog2(MAX_WAIT + 1);

  logic [DEPTH-1:0]   r_vld;
  logic [4:0]         r_addr [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [31:0]        r_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_AGE_W-1:0] r_age;

  logic               w_found;
  logic [c_PTR_W-1:0] w_head_idx;
  logic [c_CNT_W-1:0] w_skip;
  logic [c_CNT_W-1:0] w_pop_n;
  logic [DEPTH-1:0]   w_pop_mask;
  logic               w_wb_req;
  logic               w_starve;
  logic               w_wb_we;
  logic               w_md_grant;
  logic               w_md_ready;
  logic               w_push;
  logic               w_head_sq;

  // Squashed entries ahead of the first live one are dropped for free, so
  // they never cost a port cycle.
  always_comb begin
    logic [c_PTR_W-1:0] w_idx;
    w_found    = 1'b0;
    w_head_idx = r_rptr;
    w_skip     = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + i[c_PTR_W-1:0];
      if (!w_found && (i < int'(r_count))) begin
        if (r_vld[w_idx]) begin
          w_found    = 1'b1;
          w_head_idx = w_idx;
        end else begin
          w_skip = w_skip + c_CNT_W'(1);
        end
      end
    end
  end

  assign w_wb_req   = bus.wb_valid && (bus.wb_addr != 5'd0);
  assign w_starve   = w_found && (r_age == c_AGE_W'(MAX_WAIT)) && w_wb_req;
  assign w_wb_we    = !reset && w_wb_req && !w_starve;
  assign w_md_grant = !reset && w_found && (w_starve || !w_wb_req);
  assign w_md_ready = !reset && (r_count < c_CNT_W'(DEPTH));
  assign w_push     = w_md_ready && bus.md_valid && (bus.md_addr != 5'd0);
  assign w_pop_n    = w_skip + c_CNT_W'(w_md_grant);
  assign w_head_sq  = w_wb_we && w_found && (r_addr[w_head_idx] == bus.wb_addr);

  always_comb begin
    logic [c_PTR_W-1:0] w_pidx;
    w_pop_mask = '0;
    w_pidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pidx = r_rptr + i[c_PTR_W-1:0];
      if (i < int'(w_pop_n)) begin
        w_pop_mask[w_pidx] = 1'b1;
      end
    end
  end

  assign bus.md_ready = w_md_ready;
  assign bus.wb_stall = !reset && w_starve;

  always_comb begin
    bus.grf_we  = 1'b0;
    bus.grf_a3  = 5'd0;
    bus.grf_wd  = 32'd0;
    bus.grf_wpc = 32'd0;
    if (w_md_grant) begin
      bus.grf_we  = 1'b1;
      bus.grf_a3  = r_addr[w_head_idx];
      bus.grf_wd  = r_data[w_head_idx];
      bus.grf_wpc = r_pc[w_head_idx];
    end else if (w_wb_we) begin
      bus.grf_we  = 1'b1;
      bus.grf_a3  = bus.wb_addr;
      bus.grf_wd  = bus.wb_data;
      bus.grf_wpc = bus.wb_pc;
    end
  end

  // Popped and squashed slots have r_vld cleared, so r_vld alone marks live entries.
  always_comb begin
    bus.rs_pending = 1'b0;
    bus.rt_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == bus.rs_addr)) bus.rs_pending = 1'b1;
      if (r_vld[i] && (r_addr[i] == bus.rt_addr)) bus.rt_pending = 1'b1;
    end
    if (reset || (bus.rs_addr == 5'd0)) bus.rs_pending = 1'b0;
    if (reset || (bus.rt_addr == 5'd0)) bus.rt_pending = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_age   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop_mask[i] || (w_wb_we && (r_addr[i] == bus.wb_addr))) begin
          r_vld[i] <= 1'b0;
        end
      end
      // A push lands in a free slot, so it is never caught by this cycle's squash.
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + c_PTR_W'(1);
      end
      r_rptr  <= r_rptr + w_pop_n[c_PTR_W-1:0];
      r_count <= r_count - w_pop_n + c_CNT_W'(w_push);
      if (!w_found || w_md_grant || w_head_sq) begin
        r_age <= '0;
      end else if (r_age != c_AGE_W'(MAX_WAIT)) begin
        r_age <= r_age + c_AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= bus.md_addr;
      r_data[r_wptr] <= bus.md_data;
      r_pc[r_wptr]   <= bus.md_pc;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_wb_arbiter
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_wb_arbiter;
  localparam int c_DEPTH = 2;
  localparam int c_MAXW  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grf_wb_arbiter_if bus ();

  grf_wb_arbiter #(.DEPTH(c_DEPTH), .MAX_WAIT(c_MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          ok;
  } ent_t;

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0; bus.wb_pc = 32'd0;
    bus.md_valid = 1'b0; bus.md_addr = 5'd0; bus.md_data = 32'd0; bus.md_pc = 32'd0;
    bus.rs_addr  = 5'd0; bus.rt_addr = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1;
      bus.md_valid = 1'b1; bus.md_addr = 5'd3; bus.md_data = 32'h33;
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd4;
      bus.rs_addr = 5'd3;
      #1;
      total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL reset_md_ready got=%0b want=0", bus.md_ready); end
      total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL reset_grf_we got=%0b want=0", bus.grf_we); end
      total++; if (bus.wb_stall !== 1'b0) begin bad++; $display("FAIL reset_wb_stall got=%0b want=0", bus.wb_stall); end
      total++; if (bus.rs_pending !== 1'b0) begin bad++; $display("FAIL reset_rs_pending got=%0b want=0", bus.rs_pending); end
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    bus.rs_addr = 5'd3;
    #1;
    total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL post_reset_md_ready got=%0b want=1", bus.md_ready); end
    total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL post_reset_grf_we got=%0b want=0", bus.grf_we); end
    total++; if (bus.rs_pending !== 1'b0) begin bad++; $display("FAIL post_reset_pending got=%0b want=0", bus.rs_pending); end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.md_valid = 1'b1; bus.md_addr = 5'd5; bus.md_data = 32'h1234; bus.md_pc = 32'h3000;
    bus.rs_addr = 5'd5;
    #1;
    total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL lat_ready got=%0b want=1", bus.md_ready); end
    total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL lat_we_n got=%0b want=0", bus.grf_we); end
    total++; if (bus.rs_pending !== 1'b0) begin bad++; $display("FAIL lat_pend_n got=%0b want=0", bus.rs_pending); end
    @(negedge clk);
    bus.md_valid = 1'b0;
    #1;
    total++; if (bus.rs_pending !== 1'b1) begin bad++; $display("FAIL lat_pend_n1 got=%0b want=1", bus.rs_pending); end
    total++; if ({bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_wpc} !== {1'b1, 5'd5, 32'h1234, 32'h3000})
      begin bad++; $display("FAIL lat_write got=%0b/%0d/%h/%h want=1/5/1234/3000", bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_wpc); end
    @(negedge clk);
    #1;
    total++; if (bus.rs_pending !== 1'b0) begin bad++; $display("FAIL lat_pend_n2 got=%0b want=0", bus.rs_pending); end
    total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL lat_we_n2 got=%0b want=0", bus.grf_we); end
  endtask

  task automatic test_starve();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.wb_valid = (c <= 6); bus.wb_addr = 5'd8; bus.wb_data = 32'h88; bus.wb_pc = 32'h800;
      bus.md_valid = (c <= 5);
      bus.md_addr  = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
      bus.md_data  = (c == 0) ? 32'hA0 : (c == 1) ? 32'hB0 : 32'hC0;
      bus.md_pc    = 32'h100 + 32'(c);
      #1;
      if (c >= 2 && c <= 5) begin
        total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL starve_full_ready c=%0d got=%0b want=0", c, bus.md_ready); end
      end
      if (c <= 4 || c == 6) begin
        total++; if ({bus.wb_stall, bus.grf_we, bus.grf_a3, bus.grf_wd} !== {1'b0, 1'b1, 5'd8, 32'h88})
          begin bad++; $display("FAIL starve_wb c=%0d got=%0b/%0b/%0d/%h want=0/1/8/88", c, bus.wb_stall, bus.grf_we, bus.grf_a3, bus.grf_wd); end
      end
      if (c == 5) begin
        total++; if ({bus.wb_stall, bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_wpc} !== {1'b1, 1'b1, 5'd10, 32'hA0, 32'h100})
          begin bad++; $display("FAIL starve_head got=%0b/%0b/%0d/%h/%h want=1/1/10/a0/100", bus.wb_stall, bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_wpc); end
      end
      if (c == 6) begin
        total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL starve_ready_after got=%0b want=1", bus.md_ready); end
      end
      if (c == 7) begin
        total++; if ({bus.grf_we, bus.grf_a3, bus.grf_wd} !== {1'b1, 5'd11, 32'hB0})
          begin bad++; $display("FAIL starve_drain got=%0b/%0d/%h want=1/11/b0", bus.grf_we, bus.grf_a3, bus.grf_wd); end
      end
      if (c == 8) begin
        total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL starve_empty got=%0b want=0", bus.grf_we); end
      end
    end
  endtask

  task automatic test_squash();
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h8;
    bus.md_valid = 1'b1; bus.md_addr = 5'd9; bus.md_data = 32'h5555; bus.md_pc = 32'h40;
    bus.rt_addr = 5'd9;
    @(negedge clk);
    bus.md_valid = 1'b0;
    bus.wb_addr = 5'd9; bus.wb_data = 32'hAAAA; bus.wb_pc = 32'h44;
    #1;
    total++; if (bus.rt_pending !== 1'b1) begin bad++; $display("FAIL squash_pend_before got=%0b want=1", bus.rt_pending); end
    total++; if ({bus.wb_stall, bus.grf_a3, bus.grf_wd} !== {1'b0, 5'd9, 32'hAAAA})
      begin bad++; $display("FAIL squash_wb got=%0b/%0d/%h want=0/9/aaaa", bus.wb_stall, bus.grf_a3, bus.grf_wd); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.wb_valid = 1'b0;
      #1;
      total++; if (bus.rt_pending !== 1'b0) begin bad++; $display("FAIL squash_pend_after c=%0d got=%0b want=0", c, bus.rt_pending); end
      total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL squash_stale c=%0d got=%0b/%0d/%h want=0", c, bus.grf_we, bus.grf_a3, bus.grf_wd); end
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.md_valid = 1'b1; bus.md_addr = 5'd0; bus.md_data = 32'hDEAD;
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hBEEF;
      bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
      #1;
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL zero_ready c=%0d got=%0b want=1", c, bus.md_ready); end
      total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL zero_we c=%0d got=%0b want=0", c, bus.grf_we); end
      total++; if ({bus.rs_pending, bus.rt_pending} !== 2'b00) begin bad++; $display("FAIL zero_pend c=%0d got=%b want=00", c, {bus.rs_pending, bus.rt_pending}); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd8;
      bus.md_valid = 1'b1; bus.md_addr = 5'(20 + c); bus.md_data = 32'(c);
    end
    @(negedge clk);
    bus.md_valid = 1'b0;
    bus.rs_addr = 5'd20; bus.rt_addr = 5'd21;
    #1;
    total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0b want=0", bus.md_ready); end
    total++; if ({bus.rs_pending, bus.rt_pending} !== 2'b11) begin bad++; $display("FAIL mid_pend_full got=%b want=11", {bus.rs_pending, bus.rt_pending}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({bus.md_ready, bus.grf_we} !== 2'b00) begin bad++; $display("FAIL mid_in_reset got=%b want=00", {bus.md_ready, bus.grf_we}); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.wb_valid = 1'b0;
      #1;
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after c=%0d got=%0b want=1", c, bus.md_ready); end
      total++; if (bus.grf_we !== 1'b0) begin bad++; $display("FAIL mid_dropped c=%0d got=%0b/%0d want=0", c, bus.grf_we, bus.grf_a3); end
      total++; if ({bus.rs_pending, bus.rt_pending} !== 2'b00) begin bad++; $display("FAIL mid_pend_after c=%0d got=%b want=00", c, {bus.rs_pending, bus.rt_pending}); end
    end
  endtask

  // Randomized traffic: the model keeps md results as a queue of entries that
  // a younger writeback can kill; dead entries at the front vanish for free.
  task automatic test_random();
    ent_t        q[$];
    int          age;
    bit          hold;
    bit          e_we, e_stall, e_ready, e_rsp, e_rtp, hv, wbreq, grant;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_wpc;
    ent_t        ne;
    do_reset();
    age  = 0;
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      if (!hold) begin
        bus.wb_valid = ($urandom_range(0, 99) < 55);
        bus.wb_addr  = 5'($urandom_range(0, 7));
        bus.wb_data  = $urandom;
        bus.wb_pc    = $urandom;
      end
      bus.md_valid = ($urandom_range(0, 99) < 50);
      bus.md_addr  = 5'($urandom_range(0, 7));
      bus.md_data  = $urandom;
      bus.md_pc    = $urandom;
      bus.rs_addr  = 5'($urandom_range(0, 7));
      bus.rt_addr  = 5'($urandom_range(0, 7));
      #1;
      e_we = 0; e_a3 = 0; e_wd = 0; e_wpc = 0; e_stall = 0; e_ready = 0; e_rsp = 0; e_rtp = 0;
      grant = 0; hv = 0; wbreq = 0;
      if (!reset) begin
        e_ready = (q.size() < c_DEPTH);
        while (q.size() > 0 && !q[0].ok) q.delete(0);
        hv    = (q.size() > 0);
        wbreq = bus.wb_valid && (bus.wb_addr != 5'd0);
        e_stall = hv && (age == c_MAXW) && wbreq;
        grant   = hv && (e_stall || !wbreq);
        if (grant) begin
          e_we = 1; e_a3 = q[0].addr; e_wd = q[0].data; e_wpc = q[0].pc;
        end else if (wbreq) begin
          e_we = 1; e_a3 = bus.wb_addr; e_wd = bus.wb_data; e_wpc = bus.wb_pc;
        end
        foreach (q[i]) begin
          if (q[i].ok && q[i].addr == bus.rs_addr && bus.rs_addr != 0) e_rsp = 1;
          if (q[i].ok && q[i].addr == bus.rt_addr && bus.rt_addr != 0) e_rtp = 1;
        end
      end
      total++; if ({bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_wpc} !== {e_we, e_a3, e_wd, e_wpc})
        begin bad++; $display("FAIL rnd_port c=%0d got=%0b/%0d/%h/%h want=%0b/%0d/%h/%h", c, bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_wpc, e_we, e_a3, e_wd, e_wpc); end
      total++; if (bus.wb_stall !== e_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b want=%0b", c, bus.wb_stall, e_stall); end
      total++; if (bus.md_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, bus.md_ready, e_ready); end
      total++; if ({bus.rs_pending, bus.rt_pending} !== {e_rsp, e_rtp})
        begin bad++; $display("FAIL rnd_pend c=%0d got=%b want=%b", c, {bus.rs_pending, bus.rt_pending}, {e_rsp, e_rtp}); end
      if (reset) begin
        q.delete();
        age = 0;
      end else begin
        if (grant) begin
          q.delete(0);
          age = 0;
        end else if (wbreq) begin
          foreach (q[i]) if (q[i].addr == bus.wb_addr) q[i].ok = 0;
          if (hv && !q[0].ok) age = 0;
          else if (hv) age = (age < c_MAXW) ? age + 1 : c_MAXW;
        end
        if (!hv) age = 0;
        if (bus.md_valid && e_ready && bus.md_addr != 5'd0) begin
          ne.addr = bus.md_addr; ne.data = bus.md_data; ne.pc = bus.md_pc; ne.ok = 1;
          q.push_back(ne);
        end
      end
      hold = e_stall;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_latency();
    test_starve();
    test_squash();
    test_zero_addr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
